avmm_vga_fifo_writer: RTL and testbench

Parametrised Avalon-MM slave that replaces the single-register VGA data PIO with a buffered write path. CPU writes to the DATA register are pushed into an internal FIFO; the FIFO drains through a valid/ready stream toward the VGA pixel pipeline. Status, control and an optional low-watermark interrupt let the Nios II firmware keep the VGA side fed without polling every word.

---
 rtl/vga_fifo_pkg.sv | 19 +
 rtl/vga_sync_fifo.sv | 55 +++++
 rtl/avmm_vga_fifo_writer.sv | 127 ++++++++++++
 tb/tb_avmm_vga_fifo_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_fifo_pkg.sv
// Register map and bit positions shared by the VGA FIFO writer and its bench.
// No logic; constants only.
package vga_fifo_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    localparam int STS_EMPTY   = 0;
    localparam int STS_FULL    = 1;
    localparam int STS_OVF     = 2;
    localparam int STS_IRQ     = 3;
    localparam int STS_LVL_LSB = 16;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/vga_sync_fifo.sv
// Show-ahead synchronous FIFO with separate level counter and synchronous flush.
// Latency: push visible at dout/level one cycle later; pop advances head next cycle.
// Backpressure: none internally; caller must not push when full without a pop, nor pop when empty.
module vga_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;

    // Storage is reset so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (pop) r_rptr <= r_rptr + 1'b1;
            if (push && !pop)      r_level <= r_level + 1'b1;
            else if (pop && !push) r_level <= r_level - 1'b1;
        end
    end

    assign dout  = r_mem[r_rptr];
    assign level = r_level;
    assign full  = (r_level == LVL_W'(DEPTH));
    assign empty = (r_level == '0);

endmodule

// File: rtl/avmm_vga_fifo_writer.sv
// Avalon-MM slave buffering CPU DATA writes into a FIFO drained by a valid/ready stream.
// Latency: zero-wait-state reads; pushed word reaches out_data one cycle later; irq registered.
// Backpressure: out_ready stalls the stream; CPU writes into a full FIFO are dropped and flag overflow.
// Optional low-watermark interrupt and THRESH register enabled by defining VGA_FIFO_IRQ_EN.
module avmm_vga_fifo_writer
    import vga_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    logic              w_wr;
    logic              w_wr_data;
    logic              w_wr_sts;
    logic              w_wr_ctrl;
    logic              w_flush;
    logic              w_pop_req;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;
    logic [LVL_W-1:0]  w_thresh;
    logic [DATA_W-1:0] w_dout;

    logic              r_en;
    logic              r_ovf;
    logic [DATA_W-1:0] r_last_wr;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_data = w_wr & (address == ADDR_DATA);
    assign w_wr_sts  = w_wr & (address == ADDR_STATUS);
    assign w_wr_ctrl = w_wr & (address == ADDR_CTRL);
    assign w_flush   = w_wr_ctrl & writedata[CTRL_FLUSH];

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_pop_req = out_valid & out_ready;
    assign w_pop     = w_pop_req & ~w_flush;
    assign w_push    = w_wr_data & ~w_flush & (~w_full | w_pop_req);
    assign w_ovf_set = w_wr_data & ~w_flush & w_full & ~w_pop_req;

    vga_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (w_flush),
        .din     (writedata[DATA_W-1:0]),
        .dout    (w_dout),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign out_data  = w_dout;
    assign out_valid = r_en & ~w_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= 1'b0;
            r_ovf     <= 1'b0;
            r_last_wr <= '0;
        end else begin
            if (w_wr_ctrl) r_en <= writedata[CTRL_EN];
            if (w_ovf_set)                          r_ovf <= 1'b1;
            else if (w_wr_sts && writedata[STS_OVF]) r_ovf <= 1'b0;
            if (w_wr_data) r_last_wr <= writedata[DATA_W-1:0];
        end
    end

`ifdef VGA_FIFO_IRQ_EN
    logic [LVL_W-1:0] r_thresh;
    logic             r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_thresh <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr & (address == ADDR_THRESH)) r_thresh <= writedata[LVL_W-1:0];
            r_irq <= r_en & (w_level <= r_thresh);
        end
    end

    assign w_thresh = r_thresh;
    assign irq      = r_irq;
`else
    assign w_thresh = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[DATA_W-1:0] = r_last_wr;
            ADDR_STATUS: begin
                readdata[STS_EMPTY]              = w_empty;
                readdata[STS_FULL]               = w_full;
                readdata[STS_OVF]                = r_ovf;
                readdata[STS_IRQ]                = irq;
                readdata[STS_LVL_LSB +: LVL_W]   = w_level;
            end
            ADDR_CTRL:   readdata[CTRL_EN]    = r_en;
            ADDR_THRESH: readdata[LVL_W-1:0]  = w_thresh;
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avmm_vga_fifo_writer.sv
// Directed bench for avmm_vga_fifo_writer (DEPTH=16, DATA_W=32); irq checks depend on VGA_FIFO_IRQ_EN.
module tb_avmm_vga_fifo_writer;
    import vga_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    avmm_vga_fifo_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; out_ready = 1'b0;
        #12;
        rd(ADDR_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp %h", v, 32'h1); end
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", v, 32'h0); end
        rd(ADDR_DATA, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", v, 32'h0); end
        rd(ADDR_THRESH, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_thresh got %h exp %h", v, 32'h0); end
        checks++; if ({out_valid, irq, out_data} !== 34'h0) begin errors++;
            $display("FAIL reset_outs got v=%b i=%b d=%h exp 0 0 0", out_valid, irq, out_data); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] v;
        wr(ADDR_CTRL, 32'h1);
        for (int i = 1; i <= 3; i++) wr(ADDR_DATA, 32'hA5A5_0000 + i);
        rd(ADDR_STATUS, v);
        checks++; if ((v & ~32'h8) !== 32'h0003_0000) begin errors++; $display("FAIL stream_level got %h exp %h", v, 32'h0003_0000); end
        @(negedge clk); out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0000 + i) begin errors++;
                $display("FAIL stream_word%0d got v=%b d=%h exp 1 %h", i, out_valid, out_data, 32'hA5A5_0000 + i); end
            @(negedge clk);
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b exp 0", out_valid); end
        out_ready = 1'b0;
        rd(ADDR_STATUS, v);
        checks++; if ((v & ~32'h8) !== 32'h1) begin errors++; $display("FAIL stream_empty got %h exp %h", v, 32'h1); end
        rd(ADDR_DATA, v);
        checks++; if (v !== 32'hA5A5_0003) begin errors++; $display("FAIL stream_lastwr got %h exp %h", v, 32'hA5A5_0003); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(ADDR_CTRL, 32'h0);
        for (int i = 0; i < 17; i++) wr(ADDR_DATA, 32'h100 + i);
        rd(ADDR_STATUS, v);
        checks++; if (v !== 32'h0010_0006) begin errors++; $display("FAIL ovf_status got %h exp %h", v, 32'h0010_0006); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid got %b exp 0", out_valid); end
        rd(ADDR_DATA, v);
        checks++; if (v !== 32'h110) begin errors++; $display("FAIL ovf_lastwr got %h exp %h", v, 32'h110); end
        wr(ADDR_STATUS, 32'h4);
        rd(ADDR_STATUS, v);
        checks++; if (v !== 32'h0010_0002) begin errors++; $display("FAIL ovf_clear got %h exp %h", v, 32'h0010_0002); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        wr(ADDR_CTRL, 32'h1);
        @(negedge clk);
        out_ready = 1'b1; address = ADDR_DATA; writedata = 32'h777; chipselect = 1'b1; write_n = 1'b0;
        #1;
        checks++; if (out_data !== 32'h100) begin errors++; $display("FAIL fullpp_head got %h exp %h", out_data, 32'h100); end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
        rd(ADDR_STATUS, v);
        checks++; if (v !== 32'h0010_0002) begin errors++; $display("FAIL fullpp_status got %h exp %h", v, 32'h0010_0002); end
        checks++; if (out_data !== 32'h101) begin errors++; $display("FAIL fullpp_next got %h exp %h", out_data, 32'h101); end
    endtask

    task automatic test_flush();
        logic [31:0] v;
        wr(ADDR_CTRL, 32'h3);
        rd(ADDR_STATUS, v);
        checks++; if ((v & ~32'h8) !== 32'h1) begin errors++; $display("FAIL flush_full got %h exp %h", v, 32'h1); end
        for (int i = 0; i < 5; i++) wr(ADDR_DATA, 32'h200 + i);
        rd(ADDR_STATUS, v);
        checks++; if ((v & ~32'h8) !== 32'h0005_0000) begin errors++; $display("FAIL flush_pre got %h exp %h", v, 32'h0005_0000); end
        @(negedge clk);
        out_ready = 1'b1; address = ADDR_CTRL; writedata = 32'h3; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
        rd(ADDR_STATUS, v);
        checks++; if ((v & ~32'h8) !== 32'h1) begin errors++; $display("FAIL flush_pop got %h exp %h", v, 32'h1); end
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL flush_ctrl got %h exp %h", v, 32'h1); end
        rd(ADDR_DATA, v);
        checks++; if (v !== 32'h204) begin errors++; $display("FAIL flush_lastwr got %h exp %h", v, 32'h204); end
        wr(ADDR_DATA, 32'h300);
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h300) begin errors++;
            $display("FAIL flush_reuse got v=%b d=%h exp 1 %h", out_valid, out_data, 32'h300); end
        wr(ADDR_CTRL, 32'h3);
    endtask

    task automatic test_irq();
        logic [31:0] v;
`ifdef VGA_FIFO_IRQ_EN
        wr(ADDR_THRESH, 32'h2);
        rd(ADDR_THRESH, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL irq_thresh got %h exp %h", v, 32'h2); end
        for (int i = 0; i < 4; i++) wr(ADDR_DATA, 32'h400 + i);
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lvl4 got %b exp 0", irq); end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); out_ready = 1'b0;
        rd(ADDR_STATUS, v);
        checks++; if (v[16 +: 5] !== 5'd2 || irq !== 1'b0) begin errors++;
            $display("FAIL irq_edge got lvl=%0d irq=%b exp 2 0", v[16 +: 5], irq); end
        @(negedge clk);
        rd(ADDR_STATUS, v);
        checks++; if (irq !== 1'b1 || v[STS_IRQ] !== 1'b1) begin errors++;
            $display("FAIL irq_assert got irq=%b sts=%b exp 1 1", irq, v[STS_IRQ]); end
        wr(ADDR_DATA, 32'h500);
        wr(ADDR_DATA, 32'h501);
        @(negedge clk);
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert got %b exp 0", irq); end
`else
        wr(ADDR_THRESH, 32'h5);
        rd(ADDR_THRESH, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL irq_thresh got %h exp %h", v, 32'h0); end
        @(negedge clk);
        rd(ADDR_STATUS, v);
        checks++; if (irq !== 1'b0 || v[STS_IRQ] !== 1'b0) begin errors++;
            $display("FAIL irq_tied got irq=%b sts=%b exp 0 0", irq, v[STS_IRQ]); end
`endif
    endtask

    task automatic test_midreset();
        logic [31:0] v;
        wr(ADDR_CTRL, 32'h3);
        for (int i = 0; i < 3; i++) wr(ADDR_DATA, 32'h600 + i);
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h600) begin errors++;
            $display("FAIL mrst_pre got v=%b d=%h exp 1 %h", out_valid, out_data, 32'h600); end
        #1; reset_n = 1'b0;
        #1;
        checks++; if ({out_valid, irq, out_data} !== 34'h0) begin errors++;
            $display("FAIL mrst_outs got v=%b i=%b d=%h exp 0 0 0", out_valid, irq, out_data); end
        rd(ADDR_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL mrst_status got %h exp %h", v, 32'h1); end
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mrst_ctrl got %h exp %h", v, 32'h0); end
        rd(ADDR_DATA, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mrst_data got %h exp %h", v, 32'h0); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_irq();
        test_midreset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
